// File: rtl/model_state_vector_output_pkg.sv
// Shared definitions for the state-vector path: FSM encoding, constants, size check.
package model_state_vector_output_pkg;

    localparam int unsigned MAX_DATA_SIZE = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        LOAD_U = 3'd2,
        ROW_C  = 3'd3,
        ROW_D  = 3'd4,
        EMIT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [MAX_DATA_SIZE-1:0] ZERO = 64'd0;
    localparam logic [MAX_DATA_SIZE-1:0] ONE  = 64'd1;

    // Sizes arrive sign-extended so that a negative size can never pass as a large count.
    function automatic logic size_valid(
        input logic signed [MAX_DATA_SIZE-1:0] ci,
        input logic signed [MAX_DATA_SIZE-1:0] cj,
        input logic signed [MAX_DATA_SIZE-1:0] di,
        input logic signed [MAX_DATA_SIZE-1:0] dj,
        input int unsigned                     addr_size
    );
        logic signed [MAX_DATA_SIZE-1:0] depth;
        depth = MAX_DATA_SIZE'(ONE << addr_size);
        return (ci == di) && (ci >= 64'sd1) &&
               (cj >= 64'sd1) && (cj <= depth) &&
               (dj >= 64'sd1) && (dj <= depth);
    endfunction

endpackage

// File: rtl/model_state_vector_output_if.sv
// Bus bundle between the producer/consumer and the output-equation block.
interface model_state_vector_output_if #(
    parameter int unsigned DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 ERROR;
    logic                 DATA_X_IN_ENABLE;
    logic                 DATA_U_IN_ENABLE;
    logic                 DATA_C_IN_I_ENABLE;
    logic                 DATA_C_IN_J_ENABLE;
    logic                 DATA_D_IN_I_ENABLE;
    logic                 DATA_D_IN_J_ENABLE;
    logic                 DATA_Y_OUT_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_C_I_IN;
    logic [DATA_SIZE-1:0] SIZE_C_J_IN;
    logic [DATA_SIZE-1:0] SIZE_D_I_IN;
    logic [DATA_SIZE-1:0] SIZE_D_J_IN;
    logic [DATA_SIZE-1:0] DATA_X_IN;
    logic [DATA_SIZE-1:0] DATA_U_IN;
    logic [DATA_SIZE-1:0] DATA_C_IN;
    logic [DATA_SIZE-1:0] DATA_D_IN;
    logic [DATA_SIZE-1:0] DATA_Y_OUT;

    modport master (
        output START, DATA_X_IN_ENABLE, DATA_U_IN_ENABLE,
               DATA_C_IN_I_ENABLE, DATA_C_IN_J_ENABLE,
               DATA_D_IN_I_ENABLE, DATA_D_IN_J_ENABLE,
               SIZE_C_I_IN, SIZE_C_J_IN, SIZE_D_I_IN, SIZE_D_J_IN,
               DATA_X_IN, DATA_U_IN, DATA_C_IN, DATA_D_IN,
        input  READY, ERROR, DATA_Y_OUT_ENABLE, DATA_Y_OUT
    );

    modport slave (
        input  START, DATA_X_IN_ENABLE, DATA_U_IN_ENABLE,
               DATA_C_IN_I_ENABLE, DATA_C_IN_J_ENABLE,
               DATA_D_IN_I_ENABLE, DATA_D_IN_J_ENABLE,
               SIZE_C_I_IN, SIZE_C_J_IN, SIZE_D_I_IN, SIZE_D_J_IN,
               DATA_X_IN, DATA_U_IN, DATA_C_IN, DATA_D_IN,
        output READY, ERROR, DATA_Y_OUT_ENABLE, DATA_Y_OUT
    );
endinterface

// File: rtl/model_vector_buffer.sv
// Single-write, single-read register file holding one vector (x or u).
module model_vector_buffer #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned ADDRESS_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESS_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0]    wdata,
    input  logic [ADDRESS_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0]    rdata_c
);
    localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the MAC sees x[j]/u[j] in the accept cycle.
    assign rdata_c = mem[raddr];
endmodule

// File: rtl/model_state_vector_output.sv
// y(k) = C*x(k) + D*u(k): buffers x and u, streams C and D row by row, emits one y word per row.
module model_state_vector_output
    import model_state_vector_output_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned ADDRESS_SIZE = 4
) (
    input logic                          CLK,
    input logic                          RST,
    model_state_vector_output_if.slave   bus
);
    localparam int unsigned CNT_W = ADDRESS_SIZE + 1;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     j_cnt;
    logic [DATA_SIZE-1:0] i_cnt;
    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] size_ci;
    logic [CNT_W-1:0]     size_cj;
    logic [CNT_W-1:0]     size_dj;

    logic [DATA_SIZE-1:0] y_q;
    logic                 y_en_q;
    logic                 ready_q;
    logic                 error_q;
    logic [DATA_SIZE-1:0] y_d;
    logic                 y_en_d;
    logic                 ready_d;
    logic                 error_d;

    logic                 sizes_ok_c;
    logic                 x_wr_c;
    logic                 u_wr_c;
    logic                 c_acc_c;
    logic                 d_acc_c;
    logic                 last_cj_c;
    logic                 last_dj_c;
    logic                 more_rows_c;
    logic [DATA_SIZE-1:0] x_rd_c;
    logic [DATA_SIZE-1:0] u_rd_c;
    logic [DATA_SIZE-1:0] prod_c_c;
    logic [DATA_SIZE-1:0] prod_d_c;

    // Size check on the live inputs, evaluated in the START cycle.
    assign sizes_ok_c = size_valid(MAX_DATA_SIZE'($signed(bus.SIZE_C_I_IN)),
                                   MAX_DATA_SIZE'($signed(bus.SIZE_C_J_IN)),
                                   MAX_DATA_SIZE'($signed(bus.SIZE_D_I_IN)),
                                   MAX_DATA_SIZE'($signed(bus.SIZE_D_J_IN)),
                                   ADDRESS_SIZE);

    // Element acceptance: a row's first element needs its I strobe, later ones ignore it.
    always_comb begin
        x_wr_c      = (state == LOAD_X) && bus.DATA_X_IN_ENABLE;
        u_wr_c      = (state == LOAD_U) && bus.DATA_U_IN_ENABLE;
        c_acc_c     = (state == ROW_C) && bus.DATA_C_IN_J_ENABLE &&
                      ((j_cnt != CNT_W'(ZERO)) || bus.DATA_C_IN_I_ENABLE);
        d_acc_c     = (state == ROW_D) && bus.DATA_D_IN_J_ENABLE &&
                      ((j_cnt != CNT_W'(ZERO)) || bus.DATA_D_IN_I_ENABLE);
        last_cj_c   = ((j_cnt + CNT_W'(ONE)) == size_cj);
        last_dj_c   = ((j_cnt + CNT_W'(ONE)) == size_dj);
        more_rows_c = ((i_cnt + DATA_SIZE'(ONE)) < size_ci);
        prod_c_c    = bus.DATA_C_IN * x_rd_c;
        prod_d_c    = bus.DATA_D_IN * u_rd_c;
    end

    model_vector_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_x_buf (
        .clk     (CLK),
        .we      (x_wr_c),
        .waddr   (j_cnt[ADDRESS_SIZE-1:0]),
        .wdata   (bus.DATA_X_IN),
        .raddr   (j_cnt[ADDRESS_SIZE-1:0]),
        .rdata_c (x_rd_c)
    );

    model_vector_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_u_buf (
        .clk     (CLK),
        .we      (u_wr_c),
        .waddr   (j_cnt[ADDRESS_SIZE-1:0]),
        .wdata   (bus.DATA_U_IN),
        .raddr   (j_cnt[ADDRESS_SIZE-1:0]),
        .rdata_c (u_rd_c)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.START && sizes_ok_c) next_state = LOAD_X;
            LOAD_X:  if (x_wr_c && last_cj_c)     next_state = LOAD_U;
            LOAD_U:  if (u_wr_c && last_dj_c)     next_state = ROW_C;
            ROW_C:   if (c_acc_c && last_cj_c)    next_state = ROW_D;
            ROW_D:   if (d_acc_c && last_dj_c)    next_state = EMIT;
            EMIT:    next_state = more_rows_c ? ROW_C : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output next values; registered so the strobes land in the EMIT/DONE cycles.
    always_comb begin
        y_d     = y_q;
        y_en_d  = 1'b0;
        ready_d = 1'b0;
        error_d = 1'b0;
        if (d_acc_c && last_dj_c) begin
            y_en_d = 1'b1;
            y_d    = acc + prod_d_c;
        end
        if (next_state == DONE) begin
            ready_d = 1'b1;
        end
        if ((state == IDLE) && bus.START && !sizes_ok_c) begin
            ready_d = 1'b1;
            error_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            y_q     <= '0;
            y_en_q  <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_en_q  <= y_en_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Counters, captured sizes and the accumulator.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            j_cnt   <= '0;
            i_cnt   <= '0;
            acc     <= '0;
            size_ci <= '0;
            size_cj <= '0;
            size_dj <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.START && sizes_ok_c) begin
                        size_ci <= bus.SIZE_C_I_IN;
                        size_cj <= CNT_W'(bus.SIZE_C_J_IN);
                        size_dj <= CNT_W'(bus.SIZE_D_J_IN);
                        j_cnt   <= '0;
                    end
                end
                LOAD_X: begin
                    if (x_wr_c) begin
                        j_cnt <= last_cj_c ? CNT_W'(ZERO) : j_cnt + CNT_W'(ONE);
                    end
                end
                LOAD_U: begin
                    if (u_wr_c) begin
                        if (last_dj_c) begin
                            j_cnt <= '0;
                            i_cnt <= '0;
                            acc   <= '0;
                        end else begin
                            j_cnt <= j_cnt + CNT_W'(ONE);
                        end
                    end
                end
                ROW_C: begin
                    if (c_acc_c) begin
                        acc   <= acc + prod_c_c;
                        j_cnt <= last_cj_c ? CNT_W'(ZERO) : j_cnt + CNT_W'(ONE);
                    end
                end
                ROW_D: begin
                    if (d_acc_c) begin
                        acc   <= acc + prod_d_c;
                        j_cnt <= last_dj_c ? CNT_W'(ZERO) : j_cnt + CNT_W'(ONE);
                    end
                end
                EMIT: begin
                    acc   <= '0;
                    j_cnt <= '0;
                    i_cnt <= i_cnt + DATA_SIZE'(ONE);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.DATA_Y_OUT        = y_q;
    assign bus.DATA_Y_OUT_ENABLE = y_en_q;
    assign bus.READY             = ready_q;
    assign bus.ERROR             = error_q;
endmodule

// File: tb/tb_model_state_vector_output.sv
// Directed bench for the y = C*x + D*u read-out block (DATA_SIZE=16).
module tb_model_state_vector_output;

    logic clk;
    logic rst_n;

    model_state_vector_output_if #(.DATA_SIZE(16)) bus ();

    model_state_vector_output #(
        .DATA_SIZE    (16),
        .ADDRESS_SIZE (4)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;
    int y_cycle;
    int ready_cnt;
    int ready_cycle;
    int error_cnt;
    logic [15:0] yq [$];

    logic [15:0] cm [2][2];
    logic [15:0] xv [2];
    logic [15:0] dm [2][2];
    logic [15:0] uv [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.DATA_Y_OUT_ENABLE === 1'b1) begin
            yq.push_back(bus.DATA_Y_OUT);
            y_cycle = cyc;
        end
        if (bus.READY === 1'b1) begin
            ready_cnt++;
            ready_cycle = cyc;
        end
        if (bus.ERROR === 1'b1) error_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.START              = 1'b0;
        bus.DATA_X_IN_ENABLE   = 1'b0;
        bus.DATA_U_IN_ENABLE   = 1'b0;
        bus.DATA_C_IN_I_ENABLE = 1'b0;
        bus.DATA_C_IN_J_ENABLE = 1'b0;
        bus.DATA_D_IN_I_ENABLE = 1'b0;
        bus.DATA_D_IN_J_ENABLE = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
    endtask

    task automatic set_sizes(input int ci, input int cj, input int di, input int dj);
        bus.SIZE_C_I_IN = 16'(ci);
        bus.SIZE_C_J_IN = 16'(cj);
        bus.SIZE_D_I_IN = 16'(di);
        bus.SIZE_D_J_IN = 16'(dj);
    endtask

    // One full computation; abort_row >= 0 drops reset once that row's C part is in.
    task automatic run_op(input int ci, input int cj, input int di, input int dj,
                          input int maxgap, input bit stray, input bit midstart,
                          input int abort_row);
        set_sizes(ci, cj, di, dj);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < cj; k++) begin
            gap(maxgap);
            bus.DATA_X_IN_ENABLE = 1'b1;
            bus.DATA_X_IN        = xv[k];
            tick();
            bus.DATA_X_IN_ENABLE = 1'b0;
        end
        for (int k = 0; k < dj; k++) begin
            gap(maxgap);
            bus.DATA_U_IN_ENABLE = 1'b1;
            bus.DATA_U_IN        = uv[k];
            tick();
            bus.DATA_U_IN_ENABLE = 1'b0;
        end
        for (int r = 0; r < ci; r++) begin
            if (stray && r == 0) begin
                bus.DATA_C_IN_J_ENABLE = 1'b1;
                bus.DATA_C_IN_I_ENABLE = 1'b0;
                bus.DATA_C_IN          = 16'h7777;
                tick();
                bus.DATA_C_IN_J_ENABLE = 1'b0;
            end
            for (int k = 0; k < cj; k++) begin
                gap(maxgap);
                bus.DATA_C_IN_J_ENABLE = 1'b1;
                bus.DATA_C_IN_I_ENABLE = (k == 0) || stray;
                bus.DATA_C_IN          = cm[r][k];
                tick();
                bus.DATA_C_IN_J_ENABLE = 1'b0;
                bus.DATA_C_IN_I_ENABLE = 1'b0;
            end
            if (r == abort_row) begin
                rst_n = 1'b0;
                #1;
                check("abort_y_zero", 64'(bus.DATA_Y_OUT), 64'h0);
                check("abort_yen_zero", 64'(bus.DATA_Y_OUT_ENABLE), 64'h0);
                check("abort_ready_zero", 64'(bus.READY), 64'h0);
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            for (int k = 0; k < dj; k++) begin
                gap(maxgap);
                bus.DATA_D_IN_J_ENABLE = 1'b1;
                bus.DATA_D_IN_I_ENABLE = (k == 0);
                bus.DATA_D_IN          = dm[r][k];
                tick();
                bus.DATA_D_IN_J_ENABLE = 1'b0;
                bus.DATA_D_IN_I_ENABLE = 1'b0;
            end
            // EMIT cycle: the block takes no elements here.
            if (midstart && r == 0) begin
                bus.SIZE_D_I_IN = 16'd3;
                bus.START       = 1'b1;
            end
            tick();
            bus.START = 1'b0;
            set_sizes(ci, cj, di, dj);
        end
    endtask

    task automatic wait_ready(input int base);
        for (int k = 0; k < 20 && ready_cnt == base; k++) tick();
        check("ready_seen", 64'(ready_cnt), 64'(base + 1));
    endtask

    task automatic load_case1();
        cm[0][0] = 16'd1; cm[0][1] = 16'd2;
        cm[1][0] = 16'd3; cm[1][1] = 16'd4;
        xv[0]    = 16'd5; xv[1]    = 16'd6;
        dm[0][0] = 16'd1; dm[1][0] = 16'd2;
        uv[0]    = 16'd7;
    endtask

    task automatic case1(input string tag, input int maxgap, input bit stray, input bit midstart);
        int base_r;
        int base_e;
        base_r = ready_cnt;
        base_e = error_cnt;
        yq.delete();
        load_case1();
        run_op(2, 2, 2, 1, maxgap, stray, midstart, -1);
        wait_ready(base_r);
        check({tag, "_ycount"}, 64'(yq.size()), 64'd2);
        if (yq.size() == 2) begin
            check({tag, "_y0"}, 64'(yq[0]), 64'd24);
            check({tag, "_y1"}, 64'(yq[1]), 64'd53);
        end
        check({tag, "_ready_lat"}, 64'(ready_cycle - y_cycle), 64'd1);
        check({tag, "_no_error"}, 64'(error_cnt - base_e), 64'd0);
        tick();
        check({tag, "_ready_pulse"}, 64'(bus.READY), 64'h0);
    endtask

    initial begin
        int base_r;
        n_checks = 0; n_errors = 0; cyc = 0;
        ready_cnt = 0; error_cnt = 0; y_cycle = 0; ready_cycle = 0;
        rst_n = 1'b0;
        clear_strobes();
        set_sizes(0, 0, 0, 0);
        bus.DATA_X_IN = '0; bus.DATA_U_IN = '0;
        bus.DATA_C_IN = '0; bus.DATA_D_IN = '0;
        repeat (3) tick();
        check("reset_y", 64'(bus.DATA_Y_OUT), 64'h0);
        check("reset_yen", 64'(bus.DATA_Y_OUT_ENABLE), 64'h0);
        check("reset_ready", 64'(bus.READY), 64'h0);
        check("reset_error", 64'(bus.ERROR), 64'h0);
        rst_n = 1'b1;
        tick();

        // Nominal back-to-back run.
        case1("nominal", 0, 1'b0, 1'b0);

        // Wrap: 0x100*0x100 drops out of 16 bits, leaving 0xFFFF*1.
        cm[0][0] = 16'h0100; xv[0] = 16'h0100; dm[0][0] = 16'hFFFF; uv[0] = 16'h0001;
        yq.delete();
        base_r = ready_cnt;
        run_op(1, 1, 1, 1, 0, 1'b0, 1'b0, -1);
        wait_ready(base_r);
        check("wrap_ycount", 64'(yq.size()), 64'd1);
        if (yq.size() == 1) check("wrap_y", 64'(yq[0]), 64'hFFFF);

        // Invalid sizes: C rows differ from D rows, then C columns beyond the buffer.
        yq.delete();
        base_r = ready_cnt;
        set_sizes(2, 2, 3, 1);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("inv_rows_ready", 64'(bus.READY), 64'h1);
        check("inv_rows_error", 64'(bus.ERROR), 64'h1);
        set_sizes(1, 17, 1, 1);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("inv_cols_ready", 64'(bus.READY), 64'h1);
        check("inv_cols_error", 64'(bus.ERROR), 64'h1);
        bus.DATA_X_IN_ENABLE = 1'b1; bus.DATA_U_IN_ENABLE = 1'b1;
        bus.DATA_C_IN_I_ENABLE = 1'b1; bus.DATA_C_IN_J_ENABLE = 1'b1;
        bus.DATA_D_IN_I_ENABLE = 1'b1; bus.DATA_D_IN_J_ENABLE = 1'b1;
        repeat (4) tick();
        clear_strobes();
        tick();
        check("inv_ready_total", 64'(ready_cnt - base_r), 64'd2);
        check("inv_error_total", 64'(error_cnt), 64'd2);
        check("inv_no_y", 64'(yq.size()), 64'd0);

        // Gaps, a stray headless C element, stray I strobes and a mid-run START.
        case1("stall", 3, 1'b1, 1'b1);

        // Reset during row 1's D phase, then a clean rerun.
        yq.delete();
        base_r = ready_cnt;
        load_case1();
        run_op(2, 2, 2, 1, 0, 1'b0, 1'b0, 1);
        repeat (5) tick();
        check("abort_no_ready", 64'(ready_cnt), 64'(base_r));
        check("abort_ycount", 64'(yq.size()), 64'd1);
        case1("after_reset", 0, 1'b0, 1'b0);

        // 1x1 edge with a negative coefficient.
        cm[0][0] = 16'hFFFD; xv[0] = 16'd4; dm[0][0] = 16'd2; uv[0] = 16'd5;
        yq.delete();
        base_r = ready_cnt;
        run_op(1, 1, 1, 1, 0, 1'b0, 1'b0, -1);
        wait_ready(base_r);
        check("one_ycount", 64'(yq.size()), 64'd1);
        if (yq.size() == 1) check("one_y", 64'(yq[0]), 64'hFFFE);
        check("one_ready_lat", 64'(ready_cycle - y_cycle), 64'd1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/model_state_vector_output.md
Name: model_state_vector_output

Overview:
- Computes the state-space output equation y(k) = C·x(k) + D·u(k). It is the read-out end of the state-vector path: it consumes the state vector x produced by the state-update block and the input vector u, and streams the output vector y.
- x and u are buffered internally. C and D are streamed row by row, one multiply-accumulate per accepted element.
- Each y[i] is emitted as a single-cycle strobed word.

Parameters:
- DATA_SIZE, 64, width of every data and size word (two's-complement integer).
- ADDRESS_SIZE, 4, buffer address width; x and u buffers each hold 2^ADDRESS_SIZE words.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  begin a computation; sampled only in IDLE
- READY  out  1  one-cycle pulse at completion
- ERROR  out  1  one-cycle pulse coincident with READY when the sizes are invalid
- DATA_X_IN_ENABLE  in  1  valid strobe for DATA_X_IN
- DATA_U_IN_ENABLE  in  1  valid strobe for DATA_U_IN
- DATA_C_IN_I_ENABLE  in  1  marks the first element of a C row
- DATA_C_IN_J_ENABLE  in  1  valid strobe for DATA_C_IN
- DATA_D_IN_I_ENABLE  in  1  marks the first element of a D row
- DATA_D_IN_J_ENABLE  in  1  valid strobe for DATA_D_IN
- DATA_Y_OUT_ENABLE  out  1  valid strobe for DATA_Y_OUT
- SIZE_C_I_IN, SIZE_C_J_IN, SIZE_D_I_IN, SIZE_D_J_IN  in  DATA_SIZE  matrix dimensions, sampled at START
- DATA_X_IN, DATA_U_IN, DATA_C_IN, DATA_D_IN  in  DATA_SIZE  element data
- DATA_Y_OUT  out  DATA_SIZE  output element y[i]

Behaviour:

Reset:
- RST low asynchronously forces IDLE.
- All outputs go to 0; counters and the accumulator are cleared.
- Buffer contents are undefined and are not cleared.

Sizes:
- Registered on the START cycle.
- Valid when all of the following hold: SIZE_C_I = SIZE_D_I ≥ 1; 1 ≤ SIZE_C_J ≤ 2^ADDRESS_SIZE; 1 ≤ SIZE_D_J ≤ 2^ADDRESS_SIZE.
- Invalid sizes: the cycle after START, READY=1 and ERROR=1, then IDLE. No other input is consumed.

FSM:
- IDLE: on START with valid sizes, go to LOAD_X and clear the j counter.
- LOAD_X: each cycle with DATA_X_IN_ENABLE=1 writes x[j] and increments j. After SIZE_C_J writes, clear j and go to LOAD_U.
- LOAD_U: same as LOAD_X, writing u[j] for SIZE_D_J words. Then clear i and j, clear the accumulator, go to ROW_C.
- ROW_C: an element is accepted when DATA_C_IN_J_ENABLE=1, and, for j=0, DATA_C_IN_I_ENABLE=1.
  - A j=0 element without I_ENABLE is ignored and not counted.
  - I_ENABLE at j≠0 is ignored.
  - On accept: acc += DATA_C_IN·x[j]. After SIZE_C_J accepts, clear j and go to ROW_D.
- ROW_D: same acceptance rules using the D strobes; acc += DATA_D_IN·u[j]. After SIZE_D_J accepts, go to EMIT.
- EMIT (one cycle): DATA_Y_OUT=acc, DATA_Y_OUT_ENABLE=1. Clear acc and j, increment i.
  - If i+1 < SIZE_C_I, go to ROW_C.
  - Otherwise go to DONE.
- DONE (one cycle): READY=1, go to IDLE.

Timing and handshake:
- y[i] appears exactly 1 cycle after the last D element of row i is accepted.
- READY follows the final DATA_Y_OUT_ENABLE by 1 cycle.
- Gaps (enable low) stall the block indefinitely with no timeout.
- Enables that do not belong to the current state are ignored.
- START outside IDLE is ignored.

Arithmetic:
- Products and sums are computed modulo 2^DATA_SIZE: keep the low DATA_SIZE bits of the product and let the sum wrap.
- No saturation, no overflow flag.

Outputs:
- DATA_Y_OUT holds its last value when DATA_Y_OUT_ENABLE=0.
- DATA_Y_OUT_ENABLE, READY and ERROR are each high for exactly one cycle.

Reset mid-operation:
- Abort immediately; no READY is produced.
- A new START after reset release restarts from LOAD_X.

Decomposition:
- Shared package (with the state block): state encoding enum (IDLE, LOAD_X, LOAD_U, ROW_C, ROW_D, EMIT, DONE), ZERO/ONE constants, and the size-validity function.
- One natural sub-module: model_vector_buffer, a 2^ADDRESS_SIZE × DATA_SIZE single-write, single-read register file. It is instantiated twice, for x and u.

Test Plan:
1. Nominal, DATA_SIZE=16, ADDRESS_SIZE=4. Inputs: C=[[1,2],[3,4]], x=[5,6], D=[[1],[2]], u=[7], back-to-back strobes. Required: Y strobes 24 then 53, then READY, ERROR=0.
2. Wrap, DATA_SIZE=16. Inputs: C=[[0x0100]], x=[0x0100], D=[[0xFFFF]], u=[1]. Required: y=0xFFFF (C·x wraps to 0).
3. Invalid sizes. Inputs: SIZE_C_I=2, SIZE_D_I=3, or SIZE_C_J=17. Required: READY=ERROR=1 one cycle after START, no DATA_Y_OUT_ENABLE, subsequent strobes ignored.
4. Stalls and strobe rules. Run case 1 with random 0–3 cycle gaps, one extra C strobe at j=0 without I_ENABLE, and START pulsed mid-run. Required: identical outputs 24, 53; the stray strobe is not counted; the mid-run START is ignored.
5. Reset mid-ROW_D. Drive RST low during row 1. Required: outputs zero asynchronously, no READY. A fresh run of case 1 then yields 24, 53.
6. Size 1×1 edge. Inputs: C=[[-3]], x=[4], D=[[2]], u=[5]. Required: y=−2 (0xFFFE); READY exactly 1 cycle after the Y strobe.
